// File: rtl/mem_stage_lsu_if.sv
// rtl/mem_stage_lsu_if.sv - EX->MEM bundle, data-SRAM response and MEM->WB signal group
interface mem_stage_lsu_if #(
  parameter int XLEN    = 32,
  parameter int PC_W    = 32,
  parameter int RA_W    = 5,
  parameter int STALL_W = 6
);
  logic [STALL_W-1:0] stall;
  logic               flush;

  logic               ex_valid;
  logic [PC_W-1:0]    ex_pc;
  logic               ex_ld;
  logic [1:0]         ex_size;
  logic               ex_sext;
  logic [1:0]         ex_off;
  logic               ex_rf_we;
  logic [RA_W-1:0]    ex_rf_waddr;
  logic [XLEN-1:0]    ex_result;

  logic               dram_rvalid;
  logic [XLEN-1:0]    dram_rdata;

  logic               stallreq;
  logic               wb_valid;
  logic [PC_W-1:0]    wb_pc;
  logic               wb_rf_we;
  logic [RA_W-1:0]    wb_rf_waddr;
  logic [XLEN-1:0]    wb_rf_wdata;

  modport master (
    output stall, flush,
    output ex_valid, ex_pc, ex_ld, ex_size, ex_sext, ex_off, ex_rf_we, ex_rf_waddr, ex_result,
    output dram_rvalid, dram_rdata,
    input  stallreq, wb_valid, wb_pc, wb_rf_we, wb_rf_waddr, wb_rf_wdata
  );

  modport slave (
    input  stall, flush,
    input  ex_valid, ex_pc, ex_ld, ex_size, ex_sext, ex_off, ex_rf_we, ex_rf_waddr, ex_result,
    input  dram_rvalid, dram_rdata,
    output stallreq, wb_valid, wb_pc, wb_rf_we, wb_rf_waddr, wb_rf_wdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM pipeline stage: input register, load-response wait FSM, load formatting
module mem_stage_lsu #(
  parameter int XLEN    = 32,
  parameter int PC_W    = 32,
  parameter int RA_W    = 5,
  parameter int STALL_W = 6,
  parameter int STAGE   = 3
) (
  input  logic            clk,
  input  logic            rst,
  mem_stage_lsu_if.slave  bus
);

  // WB stall bit index, clamped so a mis-sized stall bus cannot index out of range
  localparam int WB_IDX = (STAGE + 1 < STALL_W) ? STAGE + 1 : STALL_W - 1;

  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] pc;
    logic            ld;
    logic [1:0]      size;
    logic            sext;
    logic [1:0]      off;
    logic            rf_we;
    logic [RA_W-1:0] rf_waddr;
    logic [XLEN-1:0] result;
  } stage_t;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, HAVE = 2'd2} state_t;

  stage_t          ex_in, r;
  state_t          state, state_n;
  logic            drain_pend, drain_n;
  logic [XLEN-1:0] rbuf;
  logic            stall_me, stall_wb, capture, leave, cap_load, resp;
  logic            stall_req;
  logic [XLEN-1:0] word, fmt;
  logic [7:0]      lane_b;
  logic [15:0]     lane_h;

  assign ex_in = '{valid: bus.ex_valid, pc: bus.ex_pc, ld: bus.ex_ld, size: bus.ex_size,
                   sext: bus.ex_sext, off: bus.ex_off, rf_we: bus.ex_rf_we,
                   rf_waddr: bus.ex_rf_waddr, result: bus.ex_result};

  assign stall_me = bus.stall[STAGE];
  assign stall_wb = bus.stall[WB_IDX];
  assign capture  = ~bus.flush & ~stall_me;
  // the instruction held in r is replaced at this edge (moves on, or is killed)
  assign leave    = bus.flush | ~stall_me | ~stall_wb;
  assign cap_load = capture & bus.ex_valid & bus.ex_ld;
  // a response that belongs to a flushed load is not ours
  assign resp     = bus.dram_rvalid & ~drain_pend;

  // input register: bubble on flush or when MEM stalls but WB drains, capture when MEM runs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r <= '0;
    end else if (bus.flush || (stall_me && !stall_wb)) begin
      r <= '0;
    end else if (!stall_me) begin
      r <= ex_in;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // drain flag and response buffer for a load whose data arrives while the stage is held
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drain_pend <= 1'b0;
      rbuf       <= '0;
    end else begin
      drain_pend <= drain_n;
      if (state == WAIT && resp && !leave) rbuf <= bus.dram_rdata;
    end
  end

  // next state: a replaced instruction restarts the FSM from what was just captured
  always_comb begin
    state_n = state;
    drain_n = drain_pend & ~bus.dram_rvalid;
    if (leave) begin
      if (state == WAIT && !resp) drain_n = 1'b1;
      state_n = cap_load ? WAIT : IDLE;
    end else begin
      case (state)
        IDLE:    if (r.valid && r.ld) state_n = WAIT;
        WAIT:    if (resp) state_n = HAVE;
        HAVE:    state_n = HAVE;
        default: state_n = IDLE;
      endcase
    end
  end

  // outputs: stall request, lane select/extension and the MEM->WB bundle
  always_comb begin
    stall_req = r.valid & r.ld & ~((state == HAVE) | resp);
    word      = (state == HAVE) ? rbuf : bus.dram_rdata;
    lane_b    = word[{r.off, 3'b000} +: 8];
    lane_h    = word[{r.off[1], 4'b0000} +: 16];
    case (r.size)
      2'd0:    fmt = {{(XLEN-8){r.sext & lane_b[7]}}, lane_b};
      2'd1:    fmt = {{(XLEN-16){r.sext & lane_h[15]}}, lane_h};
      default: fmt = word;
    endcase
    bus.stallreq    = stall_req;
    bus.wb_valid    = r.valid & ~stall_req;
    bus.wb_rf_we    = r.rf_we & r.valid & ~stall_req;
    bus.wb_pc       = r.pc;
    bus.wb_rf_waddr = r.rf_waddr;
    bus.wb_rf_wdata = r.ld ? fmt : r.result;
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - directed self-checking bench for mem_stage_lsu
module tb_mem_stage_lsu;
  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] ext_stall;
  int         total = 0;
  int         bad   = 0;

  mem_stage_lsu_if bus ();

  mem_stage_lsu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // pipeline control: a MEM stall request holds every stage up to and including MEM's register
  assign bus.stall = ext_stall | {1'b0, {5{bus.stallreq}}};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic put_ex(input logic [31:0] pc, input logic ld, input logic [1:0] size,
                        input logic sext, input logic [1:0] off, input logic we,
                        input logic [4:0] waddr, input logic [31:0] result);
    bus.ex_valid    = 1'b1;
    bus.ex_pc       = pc;
    bus.ex_ld       = ld;
    bus.ex_size     = size;
    bus.ex_sext     = sext;
    bus.ex_off      = off;
    bus.ex_rf_we    = we;
    bus.ex_rf_waddr = waddr;
    bus.ex_result   = result;
  endtask

  task automatic clr_ex;
    put_ex(32'h0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 5'd0, 32'h0);
    bus.ex_valid = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic sreq, input logic vld,
                         input logic we, input logic [31:0] wdata);
    chk({tag, ".sreq"},  32'(bus.stallreq), 32'(sreq));
    chk({tag, ".valid"}, 32'(bus.wb_valid), 32'(vld));
    chk({tag, ".we"},    32'(bus.wb_rf_we), 32'(we));
    chk({tag, ".wdata"}, bus.wb_rf_wdata,   wdata);
  endtask

  // load whose response arrives in the same cycle it sits in MEM
  task automatic load_now(input string tag, input logic [31:0] pc, input logic [1:0] size,
                          input logic sext, input logic [1:0] off, input logic [4:0] waddr,
                          input logic [31:0] rdata, input logic [31:0] exp);
    put_ex(pc, 1'b1, size, sext, off, 1'b1, waddr, 32'h0);
    tick;
    clr_ex;
    bus.dram_rvalid = 1'b1;
    bus.dram_rdata  = rdata;
    #3;
    chk_out(tag, 1'b0, 1'b1, 1'b1, exp);
    chk({tag, ".pc"},    bus.wb_pc, pc);
    chk({tag, ".waddr"}, 32'(bus.wb_rf_waddr), 32'(waddr));
    tick;
    bus.dram_rvalid = 1'b0;
    #3;
    chk({tag, ".bubble_sreq"},  32'(bus.stallreq), 32'd0);
    chk({tag, ".bubble_valid"}, 32'(bus.wb_valid), 32'd0);
  endtask

  task automatic alu(input string tag, input logic [31:0] pc, input logic [4:0] waddr,
                     input logic [31:0] result);
    put_ex(pc, 1'b0, 2'd2, 1'b0, 2'd0, 1'b1, waddr, result);
    tick;
    clr_ex;
    #3;
    chk_out(tag, 1'b0, 1'b1, 1'b1, result);
    chk({tag, ".waddr"}, 32'(bus.wb_rf_waddr), 32'(waddr));
  endtask

  initial begin
    rst             = 1'b0;
    ext_stall       = 6'd0;
    bus.flush       = 1'b0;
    bus.dram_rvalid = 1'b0;
    bus.dram_rdata  = 32'h0;
    clr_ex;
    tick;
    tick;
    #3;
    chk_out("reset", 1'b0, 1'b0, 1'b0, 32'h0);
    chk("reset.pc",    bus.wb_pc, 32'h0);
    chk("reset.waddr", 32'(bus.wb_rf_waddr), 32'd0);
    tick;
    rst = 1'b1;

    // zero-latency loads across lanes and extensions
    load_now("lb_s_off3",  32'h100, 2'd0, 1'b1, 2'd3, 5'd5, 32'h80123456, 32'hFFFFFF80);
    load_now("lhu_off2",   32'h104, 2'd1, 1'b0, 2'd2, 5'd6, 32'hBEEF1234, 32'h0000BEEF);
    load_now("lh_s_off0",  32'h108, 2'd1, 1'b1, 2'd0, 5'd7, 32'h00008001, 32'hFFFF8001);
    load_now("lbu_off1",   32'h10C, 2'd0, 1'b0, 2'd1, 5'd8, 32'h0000F100, 32'h000000F1);
    load_now("size3_word", 32'h110, 2'd3, 1'b1, 2'd0, 5'd9, 32'h89ABCDEF, 32'h89ABCDEF);
    alu("alu", 32'h114, 5'd10, 32'h0BADF00D);

    // LW with the response three cycles after capture
    put_ex(32'h200, 1'b1, 2'd2, 1'b0, 2'd0, 1'b1, 5'd11, 32'h40);
    tick;
    clr_ex;
    for (int i = 0; i < 3; i++) begin
      #3;
      chk($sformatf("lw_lat.wait%0d.sreq", i),  32'(bus.stallreq), 32'd1);
      chk($sformatf("lw_lat.wait%0d.valid", i), 32'(bus.wb_valid), 32'd0);
      chk($sformatf("lw_lat.wait%0d.we", i),    32'(bus.wb_rf_we), 32'd0);
      tick;
    end
    bus.dram_rvalid = 1'b1;
    bus.dram_rdata  = 32'hCAFEF00D;
    #3;
    chk_out("lw_lat.done", 1'b0, 1'b1, 1'b1, 32'hCAFEF00D);
    chk("lw_lat.pc", bus.wb_pc, 32'h200);
    tick;
    bus.dram_rvalid = 1'b0;
    #3;
    chk("lw_lat.bubble_valid", 32'(bus.wb_valid), 32'd0);

    // response while MEM and WB are externally held -> buffered, shown after release
    put_ex(32'h300, 1'b1, 2'd0, 1'b0, 2'd1, 1'b1, 5'd12, 32'h0);
    tick;
    clr_ex;
    ext_stall       = 6'b011000;
    bus.dram_rvalid = 1'b1;
    bus.dram_rdata  = 32'h0000A500;
    #3;
    chk_out("have.c0", 1'b0, 1'b1, 1'b1, 32'h000000A5);
    tick;
    bus.dram_rvalid = 1'b0;
    bus.dram_rdata  = 32'hFFFFFFFF;
    #3;
    chk_out("have.c1", 1'b0, 1'b1, 1'b1, 32'h000000A5);
    tick;
    ext_stall = 6'd0;
    #3;
    chk_out("have.c2", 1'b0, 1'b1, 1'b1, 32'h000000A5);
    tick;
    #3;
    chk("have.after_sreq",  32'(bus.stallreq), 32'd0);
    chk("have.after_valid", 32'(bus.wb_valid), 32'd0);

    // flush while waiting, next load must skip the stale response
    put_ex(32'h400, 1'b1, 2'd2, 1'b0, 2'd0, 1'b1, 5'd3, 32'h0);
    tick;
    clr_ex;
    #3;
    chk("flush.wait_sreq", 32'(bus.stallreq), 32'd1);
    bus.flush = 1'b1;
    tick;
    bus.flush = 1'b0;
    put_ex(32'h404, 1'b1, 2'd2, 1'b0, 2'd0, 1'b1, 5'd4, 32'h0);
    #3;
    chk("flush.bubble_sreq",  32'(bus.stallreq), 32'd0);
    chk("flush.bubble_valid", 32'(bus.wb_valid), 32'd0);
    tick;
    clr_ex;
    bus.dram_rvalid = 1'b1;
    bus.dram_rdata  = 32'hDEAD0000;
    #3;
    chk("flush.stale_sreq",  32'(bus.stallreq), 32'd1);
    chk("flush.stale_valid", 32'(bus.wb_valid), 32'd0);
    tick;
    bus.dram_rdata = 32'h12345678;
    #3;
    chk_out("flush.fresh", 1'b0, 1'b1, 1'b1, 32'h12345678);
    chk("flush.fresh_pc", bus.wb_pc, 32'h404);
    tick;
    bus.dram_rvalid = 1'b0;
    #3;
    chk("flush.after_sreq", 32'(bus.stallreq), 32'd0);

    // asynchronous reset while a load is waiting
    put_ex(32'h500, 1'b1, 2'd2, 1'b0, 2'd0, 1'b1, 5'd6, 32'h88);
    tick;
    clr_ex;
    #2;
    chk("rst_mid.pre_sreq", 32'(bus.stallreq), 32'd1);
    chk("rst_mid.pre_pc",   bus.wb_pc, 32'h500);
    rst = 1'b0;
    #1;
    chk_out("rst_mid", 1'b0, 1'b0, 1'b0, 32'h0);
    chk("rst_mid.pc",    bus.wb_pc, 32'h0);
    chk("rst_mid.waddr", 32'(bus.wb_rf_waddr), 32'd0);
    tick;
    tick;
    rst = 1'b1;
    alu("post_rst_alu", 32'h600, 5'd8, 32'h1234ABCD);
    load_now("post_rst_lw", 32'h604, 2'd2, 1'b0, 2'd0, 5'd9, 32'h87654321, 32'h87654321);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
